// File: rtl/cv32e40p_instr_obi_responder.sv
// Instruction-side OBI responder: word memory with backdoor load, in-order response FIFO, sticky initiator protocol checker.
// Grant-to-rvalid latency >= 1 cycle; grant withheld at MAX_OUTSTANDING or on gnt_stall_i; responses only held by rvalid_stall_i.
module cv32e40p_instr_obi_responder #(
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         gnt_stall_i,
  input  logic                         rvalid_stall_i,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic                         busy_o,
  output logic                         protocol_err_o
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST_PTR    = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_OUTSTANDING);
  localparam logic [31:0]   MEM_DEPTH_W = 32'(MEM_DEPTH);

  logic [31:0]   mem [MEM_DEPTH];
  logic [32:0]   fifo_q [MAX_OUTSTANDING];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   paddr_q, paddr_d;
  logic          perr_q, perr_d;

  logic [31:0]   word;
  logic          oor;
  logic [AW-1:0] idx;
  logic [32:0]   push_dat;
  logic [32:0]   head;
  logic          gnt;
  logic          rvalid;
  logic          push;
  logic          pop;
  logic          viol;

  // Offset wraps for addresses below the base, hence the explicit lower-bound test.
  assign word     = (instr_addr_i - BASE_ADDR) >> 2;
  assign oor      = (instr_addr_i < BASE_ADDR) || (word >= MEM_DEPTH_W);
  assign idx      = word[AW-1:0];
  assign push_dat = oor ? {32'h0, 1'b1} : {mem[idx], 1'b0};

  // Slot check uses the registered count, so a same-cycle pop never frees a grant.
  assign gnt    = rst_n & instr_req_i & ~gnt_stall_i & (cnt_q < MAX_CNT);
  assign rvalid = rst_n & (cnt_q != '0) & ~rvalid_stall_i;
  assign push   = gnt;
  assign pop    = rvalid;
  assign head   = fifo_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    viol    = 1'b0;
    pend_d  = instr_req_i & ~gnt;
    paddr_d = instr_addr_i;

    if (push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // A request left ungranted must be held unchanged until it is granted.
    if (pend_q && (!instr_req_i || (instr_addr_i != paddr_q))) begin
      viol = 1'b1;
    end
    perr_d = perr_q | viol;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= push_dat;
    end
  end

  // Memory contents survive reset; only the backdoor port writes it.
  always_ff @(posedge clk) begin
    if (rst_n && load_we_i) begin
      mem[load_addr_i] <= load_wdata_i;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? head[32:1] : 32'h0;
  assign instr_err_o    = rvalid & head[0];
  assign busy_o         = rst_n & (cnt_q != '0);
  assign protocol_err_o = perr_q | (rst_n & viol);

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// Directed and randomized bench for the instruction OBI responder against a queue-based reference model.
module tb_cv32e40p_instr_obi_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        gs = 1'b0;
  logic        rs = 1'b0;
  logic        lwe = 1'b0;
  logic [9:0]  laddr = 10'h0;
  logic [31:0] lwdata = 32'h0;

  logic        gnt, rvalid, err, busy, perr;
  logic [31:0] rdata;

  cv32e40p_instr_obi_responder #(
    .MEM_DEPTH      (DEPTH),
    .BASE_ADDR      (BASE),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_req_i   (req),
    .instr_addr_i  (addr),
    .instr_gnt_o   (gnt),
    .instr_rvalid_o(rvalid),
    .instr_rdata_o (rdata),
    .instr_err_o   (err),
    .gnt_stall_i   (gs),
    .rvalid_stall_i(rs),
    .load_we_i     (lwe),
    .load_addr_i   (laddr),
    .load_wdata_i  (lwdata),
    .busy_o        (busy),
    .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          fails = 0;
  logic [31:0] tb_mem [DEPTH];
  logic [32:0] q [$];
  logic        pend_m = 1'b0;
  logic        perr_m = 1'b0;
  logic [31:0] paddr_m = 32'h0;
  logic        exp_gnt, exp_rv, viol;
  int          ngrant = 0;
  int          nrv_dut = 0;
  int          pushes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] resp(input logic [31:0] a);
    logic [31:0] w;
    w = (a - BASE) >> 2;
    if (a < BASE || w >= 32'(DEPTH)) return {32'h0, 1'b1};
    return {tb_mem[w[9:0]], 1'b0};
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0FF0 | 32'($urandom_range(0, 15));
    if (r == 1) return 32'h2000 + 32'($urandom_range(0, 255));
    return BASE + 32'($urandom_range(0, 4095));
  endfunction

  // Compare every output against the model, between edges.
  task automatic settle();
    logic [31:0] er;
    logic        ee;
    #1;
    exp_gnt = rst_n && req && !gs && (q.size() < MAXO);
    exp_rv  = rst_n && (q.size() != 0) && !rs;
    er = 32'h0;
    ee = 1'b0;
    if (exp_rv) begin
      er = q[0][32:1];
      ee = q[0][0];
    end
    viol = rst_n && pend_m && (!req || addr != paddr_m);
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    chk("rdata", rdata, er);
    chk("err", 32'(err), 32'(ee));
    chk("busy", 32'(busy), 32'(rst_n && q.size() != 0));
    chk("perr", 32'(perr), 32'(perr_m | viol));
    if (rvalid === 1'b1) nrv_dut++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      pend_m  = 1'b0;
      perr_m  = 1'b0;
      paddr_m = 32'h0;
    end else begin
      if (exp_rv) void'(q.pop_front());
      if (exp_gnt) begin
        q.push_back(resp(addr));
        pushes++;
      end
      if (viol) perr_m = 1'b1;
      pend_m  = req && !exp_gnt;
      paddr_m = addr;
      if (lwe) tb_mem[laddr] = lwdata;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    logic [31:0] ea [3];
    int p0, r0, cyc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      lwe    = 1'b1;
      laddr  = i[9:0];
      lwdata = (i < 4) ? 32'(32'hA0 + i) : ((i == DEPTH - 1) ? 32'hDEAD_BEEF : $urandom());
      step();
    end
    lwe = 1'b0;

    // Back-to-back fetch
    for (int k = 0; k < 5; k++) begin
      req  = (k < 4);
      addr = BASE + 32'(4 * k);
      settle();
      if (k < 4) chk("b2b_gnt", 32'(gnt), 32'd1);
      if (k > 0) begin
        chk("b2b_rv", 32'(rvalid), 32'd1);
        chk("b2b_rdata", rdata, 32'(32'hA0 + k - 1));
      end
      advance();
    end
    req = 1'b0;

    // Outstanding limit
    rs = 1'b1;
    req = 1'b1;
    addr = BASE + 32'h20;
    ngrant = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (gnt === 1'b1) ngrant++;
      advance();
    end
    settle();
    chk("lim_grants", 32'(ngrant), 32'd2);
    chk("lim_gnt", 32'(gnt), 32'd0);
    chk("lim_busy", 32'(busy), 32'd1);
    advance();
    rs = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      if (k == 0) begin
        chk("rel_rv0", 32'(rvalid), 32'd1);
        chk("rel_gnt0", 32'(gnt), 32'd0);
        chk("rel_data0", rdata, tb_mem[8]);
      end
      if (k == 1) begin
        chk("rel_rv1", 32'(rvalid), 32'd1);
        chk("rel_gnt1", 32'(gnt), 32'd1);
      end
      advance();
    end
    req = 1'b0;
    repeat (2) step();

    // Address error
    ea[0] = 32'h0FFC;
    ea[1] = 32'h2000;
    ea[2] = 32'h1FFC;
    for (int k = 0; k < 4; k++) begin
      req = (k < 3);
      if (k < 3) addr = ea[k];
      settle();
      if (k == 1 || k == 2) begin
        chk("aerr_err", 32'(err), 32'd1);
        chk("aerr_rdata", rdata, 32'h0);
      end
      if (k == 3) begin
        chk("aok_err", 32'(err), 32'd0);
        chk("aok_rdata", rdata, 32'hDEAD_BEEF);
      end
      advance();
    end
    req = 1'b0;

    // Backdoor write colliding with a grant to the same word
    req = 1'b1;
    addr = BASE;
    lwe = 1'b1;
    laddr = 10'd0;
    lwdata = 32'h5555_AAAA;
    step();
    lwe = 1'b0;
    settle();
    chk("col_old", rdata, 32'h0000_00A0);
    advance();
    req = 1'b0;
    settle();
    chk("col_new", rdata, 32'h5555_AAAA);
    advance();

    // Randomized stalls against the scoreboard
    p0 = pushes;
    r0 = nrv_dut;
    ngrant = 0;
    cyc = 0;
    while (ngrant < 200 && cyc < 5000) begin
      gs = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 3) == 0);
      if (!pend_m) begin
        req  = ($urandom_range(0, 4) != 0);
        addr = rand_addr();
      end
      lwe    = ($urandom_range(0, 7) == 0);
      laddr  = 10'($urandom_range(0, DEPTH - 1));
      lwdata = $urandom();
      settle();
      if (exp_gnt) ngrant++;
      advance();
      cyc++;
    end
    chk("rand_grants", 32'(ngrant), 32'd200);
    gs = 1'b0;
    rs = 1'b0;
    req = 1'b0;
    lwe = 1'b0;
    repeat (4) step();
    settle();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("rand_no_loss", 32'(nrv_dut - r0), 32'(pushes - p0));
    chk("pre_perr", 32'(perr), 32'd0);
    advance();

    // Protocol violation
    req = 1'b1;
    addr = 32'h10;
    gs = 1'b1;
    step();
    addr = 32'h14;
    settle();
    chk("perr_now", 32'(perr), 32'd1);
    advance();
    gs = 1'b0;
    step();
    req = 1'b0;
    repeat (3) step();
    settle();
    chk("perr_sticky", 32'(perr), 32'd1);
    advance();

    // Reset mid-operation
    rs = 1'b1;
    req = 1'b1;
    addr = BASE + 32'h8;
    step();
    addr = BASE + 32'hC;
    step();
    req = 1'b0;
    settle();
    chk("mid_busy", 32'(busy), 32'd1);
    advance();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rst_rv", 32'(rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_perr", 32'(perr), 32'd0);
      advance();
    end
    req = 1'b1;
    addr = BASE + 32'h4;
    step();
    req = 1'b0;
    settle();
    chk("rst_new_rv", 32'(rvalid), 32'd1);
    chk("rst_new_data", rdata, tb_mem[1]);
    advance();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/cv32e40p_instr_obi_responder.md
Name: cv32e40p_instr_obi_responder

Overview:
- OBI instruction-side responder: the memory end of the fetch interface that the IF-stage prefetch buffer drives (req/gnt address phase, rvalid/rdata/err response phase).
- Holds a word-addressed instruction memory and a backdoor load port.
- Supports pipelined outstanding transactions, bench-controlled grant and response stalls, and address-range error responses.
- Includes a sticky protocol checker for initiator-side OBI rule violations.
- Used as the instruction memory model in core-level simulation and as a bench responder for fetch-path verification.

Parameters:
- MEM_DEPTH, 1024: number of 32-bit words in the memory array; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- MAX_OUTSTANDING, 2: response FIFO depth, i.e. the maximum number of granted transactions still awaiting rvalid; range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_req_i  in  1  OBI address-phase request.
- instr_addr_i  in  32  byte address; bits [1:0] are ignored.
- instr_gnt_o  out  1  OBI grant; combinational.
- instr_rvalid_o  out  1  response valid.
- instr_rdata_o  out  32  response data.
- instr_err_o  out  1  response error; valid only while rvalid is high.
- gnt_stall_i  in  1  bench control: suppress grant this cycle.
- rvalid_stall_i  in  1  bench control: hold the response this cycle.
- load_we_i  in  1  backdoor write enable.
- load_addr_i  in  $clog2(MEM_DEPTH)  backdoor word index.
- load_wdata_i  in  32  backdoor write data.
- busy_o  out  1  at least one transaction outstanding.
- protocol_err_o  out  1  sticky initiator protocol violation.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Clears the FIFO, the outstanding count, the checker state and protocol_err_o.
  - While rst_n is low: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0.
  - Memory contents are not reset.
  - Reset mid-transaction discards all outstanding responses; no rvalid occurs for them afterwards.
- Address decode:
  - off = instr_addr_i - BASE_ADDR, computed as 32-bit unsigned with wrap.
  - idx = off[31:2].
  - Out of range when instr_addr_i < BASE_ADDR or idx >= MEM_DEPTH.
- Grant: instr_gnt_o = rst_n & instr_req_i & ~gnt_stall_i & (count < MAX_OUTSTANDING).
  - A pop in the same cycle does not free a slot for this cycle's grant.
- Accept (req & gnt):
  - Memory is read asynchronously at idx in the grant cycle.
  - Push {rdata, err}. In range: {mem[idx], 0}. Out of range: {32'h0, 1}.
  - Same-cycle backdoor write to the same word: the grant returns the old data; the new data is visible from the next cycle.
- Response:
  - instr_rvalid_o = (count != 0) & ~rvalid_stall_i.
  - instr_rdata_o and instr_err_o come from the FIFO head; both are 0 when instr_rvalid_o is low.
  - OBI has no response backpressure, so the head pops every cycle rvalid is high.
  - Minimum latency: rvalid in the cycle after the grant. A zero-latency response is not permitted.
  - Responses are returned strictly in grant order.
- Count:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- busy_o = (count != 0).
- Protocol checker:
  - Registers pending = req & ~gnt, together with the address.
  - If pending was set and in the current cycle instr_req_i=0, or instr_addr_i differs from the registered address, set protocol_err_o.
  - protocol_err_o stays set until reset.
  - A violation has no effect on transaction handling.
- Backdoor writes occur on any cycle where load_we_i=1 and rst_n=1.

Test Plan:
- Back-to-back fetch:
  - Stimulus: load mem[0..3] = 32'hA0..A3; hold req high on addresses 0, 4, 8, 12; no stalls.
  - Required: gnt is high every cycle; rvalid is high in cycles 1–4 with rdata A0, A1, A2, A3 in order; err=0; count never exceeds 1.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=2; rvalid_stall_i=1 for 5 cycles; req held high.
  - Required: exactly 2 grants, then gnt=0 and busy_o=1.
  - After the stall is released: two rvalids in order, then grants resume.
- Address error:
  - Stimulus: BASE_ADDR=32'h1000, MEM_DEPTH=1024; request 32'h0FFC, then 32'h2000, then 32'h1FFC.
  - Required: err=1 with rdata=0 for the first two; err=0 with rdata=mem[1023] for the third.
- Simultaneous push/pop and gnt stall:
  - Stimulus: randomized gnt_stall_i and rvalid_stall_i over 200 requests against a scoreboard.
  - Required: in-order data, zero lost or duplicated responses, count always within 0..2.
- Protocol violation:
  - Stimulus: req high with addr 32'h10 while gnt_stall_i=1; next cycle change addr to 32'h14.
  - Required: protocol_err_o=1 from that cycle onward; it stays 1 after further legal traffic.
- Reset mid-operation:
  - Stimulus: two transactions outstanding with rvalid stalled; assert rst_n=0 for 1 cycle, then release the stall.
  - Required: no rvalid occurs; busy_o=0; protocol_err_o=0; a new request returns correct data.
